// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and the control decoder:
// fetch FSM state encoding, the bubble instruction, instruction field
// positions and the opcode values the decoder switches on.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,   // one cycle after reset release, no request
    FETCH,  // request outstanding at req_addr
    HOLD,   // fetched word parked in the hold buffer while stalled
    DROP    // waiting out a reply that a redirect made stale
  } fetch_state_e;

  // Opcode 15 with zero fields: no register write, no memory access.
  localparam logic [15:0] NOP_INSTR = 16'hF000;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int FUNC_MSB   = 3;
  localparam int FUNC_LSB   = 0;

  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_BRANCH = 4'h3;
  localparam logic [3:0] OP_JUMP   = 4'h4;
  localparam logic [3:0] OP_NOP    = 4'hF;

endpackage

// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge port.
//   req   : fetch request, held until ack
//   addr  : fetch address, stable while req=1
//   ack   : one-cycle pulse, rdata valid and request complete
//   rdata : fetched instruction
// master = fetch stage, slave = instruction memory.
interface imem_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: valid flag, instruction and its PC.
//   flush : valid <= 0, instr <= NOP (pc kept), wins over load
//   load  : capture {1, d_instr, d_pc}
//   neither asserted: hold
module ifid_reg #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'hF000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_instr <= NOP_INSTR;
      q_pc    <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_instr <= NOP_INSTR;
    end else if (load) begin
      q_valid <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, feeding the control decoder.
// Owns the PC, issues one request at a time on the imem port, parks a word
// that arrives during a stall, and flushes/refetches on redirect.
//   clk, rst_n             : clock, async active-low reset
//   stall                  : hold IF/ID and PC
//   redirect_valid/_pc     : taken branch/jump, flush and refetch at target
//   imem                   : instruction-memory master port
//   ifid_valid/instr/pc    : IF/ID contents
//   ifid_opcode/funccode   : instruction field slices for the decoder
module fetch_stage #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter int                 PC_INC    = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  imem_if.master             imem,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [3:0]         ifid_opcode,
  output logic [3:0]         ifid_funccode
);
  import cpu_pkg::*;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  fetch_state_e       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    req_addr;
  logic               req_q;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc;

  logic               ack_v;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    next_fetch_pc;

  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_d_instr;
  logic [PC_W-1:0]    ifid_d_pc;

  assign imem.req  = req_q;
  assign imem.addr = req_addr;

  // An ack with no request outstanding is meaningless and ignored.
  assign ack_v         = imem.ack & req_q;
  assign pc_inc        = pc + PC_STEP;  // wraps modulo 2^PC_W
  assign next_fetch_pc = redirect_valid ? redirect_pc : pc;

  // IF/ID control. Redirect flushes even under stall.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d_instr = imem.rdata;
    ifid_d_pc    = req_addr;
    if (redirect_valid) begin
      ifid_flush = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (!stall) begin
            if (ack_v) ifid_load  = 1'b1;
            else       ifid_flush = 1'b1;  // bubble while waiting
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load    = 1'b1;
            ifid_d_instr = buf_instr;
            ifid_d_pc    = buf_pc;
          end
        end
        DROP:    if (!stall) ifid_flush = 1'b1;
        default: ;
      endcase
    end
  end

  // FSM, PC, request address and hold buffer. In FETCH, pc == req_addr.
  // The hold buffer is only read in HOLD, so leaving HOLD invalidates it.
  // NOTE: the hold buffer is reset as well, so IF/ID can never capture X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      req_q     <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          req_q    <= 1'b1;
          pc       <= next_fetch_pc;
          req_addr <= next_fetch_pc;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // imem_addr may not move under a live request: wait it out.
            if (ack_v) req_addr <= redirect_pc;
            else       state    <= DROP;
          end else if (ack_v) begin
            pc <= pc_inc;
            if (stall) begin
              buf_instr <= imem.rdata;
              buf_pc    <= req_addr;
              req_q     <= 1'b0;
              state     <= HOLD;
            end else begin
              req_addr <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            pc       <= next_fetch_pc;
            req_addr <= next_fetch_pc;
            req_q    <= 1'b1;
            state    <= FETCH;
          end
        end
        DROP: begin
          pc <= next_fetch_pc;
          if (ack_v) begin
            req_addr <= next_fetch_pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ifid_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ifid_load),
    .flush   (ifid_flush),
    .d_instr (ifid_d_instr),
    .d_pc    (ifid_d_pc),
    .q_valid (ifid_valid),
    .q_instr (ifid_instr),
    .q_pc    (ifid_pc)
  );

  assign ifid_opcode   = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign ifid_funccode = ifid_instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. A behavioural instruction memory
// answers requests after a programmable number of wait cycles, or the
// scenario drives ack/rdata by hand. Outputs are sampled on the falling edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [3:0]  ifid_opcode;
  logic [3:0]  ifid_funccode;

  imem_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_opcode    (ifid_opcode),
    .ifid_funccode  (ifid_funccode)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: auto responder or manual drive.
  logic        rsp_en;
  int          lat;
  int          cnt;
  logic        auto_ack;
  logic [15:0] auto_rdata;
  logic        man_ack;
  logic [15:0] man_rdata;

  assign bus.ack   = rsp_en ? auto_ack   : man_ack;
  assign bus.rdata = rsp_en ? auto_rdata : man_rdata;

  // {req, addr, ifid_valid, ifid_instr, ifid_pc}
  logic [49:0] snap;
  logic [49:0] exp;
  assign snap = {bus.req, bus.addr, ifid_valid, ifid_instr, ifid_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0123;
    if (a == 16'h0002) return 16'h4567;
    return {4'h1, a[11:0]};
  endfunction

  // Answers the request visible after each rising edge, lat cycles late.
  initial begin
    auto_ack   = 1'b0;
    auto_rdata = 16'h0000;
    cnt        = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.req && cnt >= lat) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_word(bus.addr);
        cnt        = 0;
      end else begin
        auto_ack = 1'b0;
        if (bus.req) cnt++;
        else         cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reset asserted over two falling edges, released on the last one.
  task automatic apply_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    man_ack        = 1'b0;
    man_rdata      = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rsp_en = 1'b1; lat = 0;
    apply_reset();
    exp = {1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL reset_state: got %h want %h", snap, exp); end
    checks++; if (ifid_opcode !== 4'hF) begin errors++; $display("FAIL reset_opcode: got %h want %h", ifid_opcode, 4'hF); end
    checks++; if (ifid_funccode !== 4'h0) begin errors++; $display("FAIL reset_funccode: got %h want %h", ifid_funccode, 4'h0); end
    @(negedge clk);
    exp = {1'b1, 16'h0000, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL reset_first_req: got %h want %h", snap, exp); end
  endtask

  task automatic test_zero_wait();
    rsp_en = 1'b1; lat = 0;
    apply_reset();
    @(negedge clk);
    exp = {1'b1, 16'h0000, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL zw_c1: got %h want %h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 16'h0002, 1'b1, 16'h0123, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL zw_c2: got %h want %h", snap, exp); end
    checks++; if (ifid_opcode !== 4'h0) begin errors++; $display("FAIL zw_opcode0: got %h want %h", ifid_opcode, 4'h0); end
    checks++; if (ifid_funccode !== 4'h3) begin errors++; $display("FAIL zw_func3: got %h want %h", ifid_funccode, 4'h3); end
    @(negedge clk);
    exp = {1'b1, 16'h0004, 1'b1, 16'h4567, 16'h0002};
    checks++; if (snap !== exp) begin errors++; $display("FAIL zw_c3: got %h want %h", snap, exp); end
    checks++; if (ifid_opcode !== 4'h4) begin errors++; $display("FAIL zw_opcode4: got %h want %h", ifid_opcode, 4'h4); end
    checks++; if (ifid_funccode !== 4'h7) begin errors++; $display("FAIL zw_func7: got %h want %h", ifid_funccode, 4'h7); end
  endtask

  task automatic test_latency();
    rsp_en = 1'b1; lat = 2;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp = {1'b1, 16'h0000, 1'b0, 16'hF000, 16'h0000};
      checks++; if (snap !== exp) begin errors++; $display("FAIL lat_wait%0d: got %h want %h", i, snap, exp); end
    end
    @(negedge clk);
    exp = {1'b1, 16'h0002, 1'b1, 16'h0123, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL lat_done: got %h want %h", snap, exp); end
  endtask

  task automatic test_stall();
    rsp_en = 1'b1; lat = 0;
    apply_reset();
    repeat (2) @(negedge clk);
    exp = {1'b1, 16'h0002, 1'b1, 16'h0123, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_pre: got %h want %h", snap, exp); end
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp = {1'b0, 16'h0002, 1'b1, 16'h0123, 16'h0000};
      checks++; if (snap !== exp) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, snap, exp); end
    end
    stall = 1'b0;
    @(negedge clk);
    exp = {1'b1, 16'h0004, 1'b1, 16'h4567, 16'h0002};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_release: got %h want %h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 16'h0006, 1'b1, 16'h1004, 16'h0004};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_next: got %h want %h", snap, exp); end
  endtask

  task automatic test_redirect();
    rsp_en = 1'b1; lat = 0;
    apply_reset();
    repeat (4) @(negedge clk);
    lat = 3;
    @(negedge clk);
    exp = {1'b1, 16'h0008, 1'b1, 16'h1006, 16'h0006};
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_pre: got %h want %h", snap, exp); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp = {1'b1, 16'h0008, 1'b0, 16'hF000, 16'h0006};
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_flush: got %h want %h", snap, exp); end
    @(negedge clk);
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_drop1: got %h want %h", snap, exp); end
    @(negedge clk);
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_drop2: got %h want %h", snap, exp); end
    lat = 0;
    @(negedge clk);
    exp = {1'b1, 16'h0040, 1'b0, 16'hF000, 16'h0006};
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_newreq: got %h want %h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 16'h0042, 1'b1, 16'h1040, 16'h0040};
    checks++; if (snap !== exp) begin errors++; $display("FAIL redir_target: got %h want %h", snap, exp); end
  endtask

  task automatic test_redirect_stall();
    rsp_en = 1'b1; lat = 0;
    apply_reset();
    repeat (2) @(negedge clk);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    exp = {1'b1, 16'h0100, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL rs_flush: got %h want %h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 16'h0102, 1'b1, 16'h1100, 16'h0100};
    checks++; if (snap !== exp) begin errors++; $display("FAIL rs_target: got %h want %h", snap, exp); end
  endtask

  task automatic test_reset_midreq_wrap();
    rsp_en = 1'b0; lat = 0;
    apply_reset();
    @(negedge clk);
    man_ack = 1'b1; man_rdata = 16'h0123;
    @(negedge clk);
    man_ack = 1'b0;
    exp = {1'b1, 16'h0002, 1'b1, 16'h0123, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL mr_pre: got %h want %h", snap, exp); end
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL mr_async: got %h want %h", snap, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    man_ack = 1'b1; man_rdata = 16'hBEEF;  // late reply, must be ignored
    checks++; if (snap !== exp) begin errors++; $display("FAIL mr_idle: got %h want %h", snap, exp); end
    @(negedge clk);
    man_ack = 1'b0;
    exp = {1'b1, 16'h0000, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL mr_refetch: got %h want %h", snap, exp); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (snap !== exp) begin errors++; $display("FAIL wrap_drop: got %h want %h", snap, exp); end
    man_ack = 1'b1; man_rdata = 16'h1234;
    @(negedge clk);
    exp = {1'b1, 16'hFFFE, 1'b0, 16'hF000, 16'h0000};
    checks++; if (snap !== exp) begin errors++; $display("FAIL wrap_req: got %h want %h", snap, exp); end
    man_rdata = 16'h9ABC;
    @(negedge clk);
    man_ack = 1'b0;
    exp = {1'b1, 16'h0000, 1'b1, 16'h9ABC, 16'hFFFE};
    checks++; if (snap !== exp) begin errors++; $display("FAIL wrap_pc: got %h want %h", snap, exp); end
    checks++; if (ifid_opcode !== 4'h9) begin errors++; $display("FAIL wrap_opcode: got %h want %h", ifid_opcode, 4'h9); end
    checks++; if (ifid_funccode !== 4'hC) begin errors++; $display("FAIL wrap_func: got %h want %h", ifid_funccode, 4'hC); end
    rsp_en = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    rsp_en         = 1'b1;
    lat            = 0;
    man_ack        = 1'b0;
    man_rdata      = 16'h0000;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_midreq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
